wshb_arbiter2: RTL and testbench
================================

# wshb_arbiter2

Two-master, one-slave Wishbone arbiter between the display path and the SDRAM controller. Masters are the VGA framebuffer reader (M0) and the test-pattern writer `mire` (M1); the slave is the SDRAM Wishbone port. The block owns grant sequencing, request and response routing, and bounded-tenure fairness, so neither master can starve the other.

## Interface
Parameters:
- `MAX_GRANT`, default 64: maximum acks in one tenure when the other master is requesting. Range 2..1023.
- `ADR_W`, default 32: address width, matching `wshb_if`.

Ports:
- `clk`  in  1  single system clock; all state on rising edge.
- `rst_n`  in  1  reset. One clock; reset is asynchronous and active-low.
- `wshb_ifs_vga`  wshb_if.slave  -  M0 port (VGA reader).
- `wshb_ifs_mire`  wshb_if.slave  -  M1 port (pattern writer).
- `wshb_ifm_sdram`  wshb_if.master  -  slave-side port to the SDRAM controller.

## Operation
- States (shared enum `gnt_t`):
  - `GNT_NONE`: no master owns the slave.
  - `GNT_VGA`: M0 owns the slave.
  - `GNT_MIRE`: M1 owns the slave.
- Request: master Mi requests when `cyc_i && stb_i`.
- Routing:
  - `adr`, `dat_ms`, `we`, `sel`, `cti`, `bte`, `cyc` and `stb` go from the owner to the slave.
  - In `GNT_NONE`, all slave-side outputs are 0.
  - Slave `ack` goes to the owner only. The non-owner's `ack` is 0.
  - Slave `dat_sm` is broadcast to both masters.
- Arbitration from `GNT_NONE`:
  - If one master requests, it is granted.
  - If both request, the master not in `last_owner` wins.
  - `last_owner` resets to M1, so M0 wins the first tie after reset.
- Release from `GNT_X` (X = owner, Y = other master):
  - Normal release: the owner's `cyc` is 0 at a clock edge. Next state is `GNT_Y` if Y requests, else `GNT_NONE`.
  - Forced release: slave `ack` is 1, `tenure_cnt == MAX_GRANT-1` and Y requests. Next state is `GNT_Y`.
  - A force-released master keeps `cyc`/`stb` asserted. It sees no ack and simply waits (legal Wishbone wait). It is regranted later through normal arbitration.
- `tenure_cnt` (width `$clog2(MAX_GRANT)`):
  - Counts slave acks during the current tenure.
  - Clears on every grant change.
  - If it reaches `MAX_GRANT-1` with an ack while Y is idle, it wraps to 0 and X keeps the grant.
- `last_owner` is updated on every transition into `GNT_VGA` or `GNT_MIRE`.
- Simultaneous events:
  - Owner drops `cyc` on the same edge as a forced-release condition: treated as normal release, same next state.
  - An ack with the owner's `cyc` at 0 is ignored and not counted.

## Timing
- Reset (`rst_n` = 0, asynchronous):
  - state `GNT_NONE`, `last_owner` = M1, `tenure_cnt` = 0.
  - All slave-side outputs 0; both master `ack` 0.
  - Reset mid-transfer drops slave `cyc` immediately; the in-flight ack is lost.
- Grant latency: a request seen at edge N in `GNT_NONE` gives a registered grant after edge N. The owner is muxed to the slave during cycle N+1. Single-cycle arbitration penalty.
- Master-to-slave path is combinational from the registered grant. No added latency per beat while granted.
- Handover on release is back-to-back. The ack at edge N goes to the old owner, and the new owner drives the slave in cycle N+1. No idle cycle is inserted, but slave `cyc` may stay high across owners.
- Ack routing uses the current registered grant, so an ack is never delivered to a master in the cycle after it lost the grant.

## Structure
- Package `wshb_arb_pkg`:
  - `typedef enum logic [1:0] {GNT_NONE, GNT_VGA, GNT_MIRE} gnt_t`.
  - Master index constants `M_VGA=0`, `M_MIRE=1`.
- Sub-module `wshb_arb_mux`: purely combinational request/response mux driven by `gnt_t`.
- Top-level `wshb_arbiter2` holds the grant FSM, `last_owner` and `tenure_cnt`.

## Test plan
- Reset, then M1 alone requests with continuous acks: grant M1 one cycle after request; 200 acks reach M1; M0 `ack` stays 0; slave `adr` tracks M1.
- Both request on the same edge after reset: M0 granted first. M0 drops `cyc` after 10 acks, and M1 drives the slave in the next cycle.
- Both hold requests continuously, `MAX_GRANT`=64: grant alternates every 64 acks. No master receives a 65th ack in one tenure; each handover is back-to-back.
- M1 owns with `tenure_cnt`=63, and M0 drops `cyc` on the same edge as M1's 64th ack: M1 keeps the grant and the counter wraps to 0.
- Owner drops `cyc` with the other master idle: state goes to `GNT_NONE` and all slave outputs are 0 next cycle. A later request is granted with 1-cycle latency.
- Assert `rst_n`=0 mid-burst, asynchronously between edges: slave `cyc`/`stb` and both acks go to 0 immediately. After release, the tie goes to M0.

Source files
------------

// File: rtl/wshb_arb_pkg.sv
// Shared types for the two-master Wishbone arbiter.
// Grant encoding, master indices and bus field widths.
package wshb_arb_pkg;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_VGA,
    GNT_MIRE
  } gnt_t;

  localparam logic M_VGA  = 1'b0;
  localparam logic M_MIRE = 1'b1;

  localparam int DAT_W = 32;
  localparam int SEL_W = 4;
  localparam int CTI_W = 3;
  localparam int BTE_W = 2;

  // Request bundle minus the address: dat, we, sel, cti, bte, cyc, stb.
  localparam int REQ_XW = DAT_W + 1 + SEL_W + CTI_W + BTE_W + 1 + 1;

  function automatic logic is_req(input logic cyc, input logic stb);
    return cyc & stb;
  endfunction

endpackage

// File: rtl/wshb_if.sv
// Classic Wishbone bus bundle shared by masters and slaves.
// The master modport drives the request; the slave drives ack and data.
interface wshb_if
  import wshb_arb_pkg::*;
#(
  parameter int ADR_W = 32
);

  logic [ADR_W-1:0] adr;
  logic [DAT_W-1:0] dat_ms;
  logic [DAT_W-1:0] dat_sm;
  logic             we;
  logic [SEL_W-1:0] sel;
  logic [CTI_W-1:0] cti;
  logic [BTE_W-1:0] bte;
  logic             cyc;
  logic             stb;
  logic             ack;

  modport master (
    output adr, dat_ms, we, sel, cti, bte, cyc, stb,
    input  dat_sm, ack
  );

  modport slave (
    input  adr, dat_ms, we, sel, cti, bte, cyc, stb,
    output dat_sm, ack
  );

endinterface

// File: rtl/wshb_arb_mux.sv
// Combinational request/response steering for the arbiter.
// Owner request goes to the slave; ack only back to the owner.
module wshb_arb_mux
  import wshb_arb_pkg::*;
#(
  parameter int RW = 76
) (
  input  gnt_t             gnt,
  input  logic [RW-1:0]    vga_req,
  input  logic [RW-1:0]    mire_req,
  output logic [RW-1:0]    sdram_req,
  input  logic             sdram_ack,
  input  logic [DAT_W-1:0] sdram_dat,
  output logic             vga_ack,
  output logic             mire_ack,
  output logic [DAT_W-1:0] vga_dat,
  output logic [DAT_W-1:0] mire_dat
);

  // Steer the owner's request out and the slave ack back to it only.
  always_comb begin
    sdram_req = '0;
    vga_ack   = 1'b0;
    mire_ack  = 1'b0;
    unique case (1'b1)
      (gnt == GNT_VGA): begin
        sdram_req = vga_req;
        vga_ack   = sdram_ack;
      end
      (gnt == GNT_MIRE): begin
        sdram_req = mire_req;
        mire_ack  = sdram_ack;
      end
      default: ;
    endcase
  end

  // Read data is harmless to broadcast; only ack qualifies it.
  assign vga_dat  = sdram_dat;
  assign mire_dat = sdram_dat;

endmodule

// File: rtl/wshb_arbiter2.sv
// Two-master Wishbone arbiter: VGA reader and pattern writer to SDRAM.
// Registered grant, round-robin ties, ack-bounded tenure when contended.
module wshb_arbiter2
  import wshb_arb_pkg::*;
#(
  parameter int MAX_GRANT = 64,
  parameter int ADR_W     = 32
) (
  input logic   clk,
  input logic   rst_n,
  wshb_if.slave  wshb_ifs_vga,
  wshb_if.slave  wshb_ifs_mire,
  wshb_if.master wshb_ifm_sdram
);

  localparam int RW    = ADR_W + REQ_XW;
  localparam int CNT_W = $clog2(MAX_GRANT);
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(MAX_GRANT - 1);

  gnt_t             gnt_q;
  gnt_t             gnt_d;
  logic             last_q;
  logic             last_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  logic req_vga;
  logic req_mire;
  logic own_cyc;
  logic ack_hit;
  logic cnt_top;

  logic [RW-1:0] vga_req;
  logic [RW-1:0] mire_req;
  logic [RW-1:0] sdram_req;

  logic             vga_ack;
  logic             mire_ack;
  logic [DAT_W-1:0] vga_dat;
  logic [DAT_W-1:0] mire_dat;

  assign req_vga  = is_req(wshb_ifs_vga.cyc, wshb_ifs_vga.stb);
  assign req_mire = is_req(wshb_ifs_mire.cyc, wshb_ifs_mire.stb);

  assign vga_req = {
    wshb_ifs_vga.adr, wshb_ifs_vga.dat_ms,
    wshb_ifs_vga.we, wshb_ifs_vga.sel,
    wshb_ifs_vga.cti, wshb_ifs_vga.bte,
    wshb_ifs_vga.cyc, wshb_ifs_vga.stb
  };

  assign mire_req = {
    wshb_ifs_mire.adr, wshb_ifs_mire.dat_ms,
    wshb_ifs_mire.we, wshb_ifs_mire.sel,
    wshb_ifs_mire.cti, wshb_ifs_mire.bte,
    wshb_ifs_mire.cyc, wshb_ifs_mire.stb
  };

  // Owner's cyc qualifies acks so stray acks are not counted.
  always_comb begin
    own_cyc = 1'b0;
    unique case (1'b1)
      (gnt_q == GNT_VGA):  own_cyc = wshb_ifs_vga.cyc;
      (gnt_q == GNT_MIRE): own_cyc = wshb_ifs_mire.cyc;
      default: ;
    endcase
  end

  assign ack_hit = wshb_ifm_sdram.ack & own_cyc;
  assign cnt_top = (cnt_q == CNT_TOP);

  // Grant FSM: idle arbitration, normal release, forced release.
  always_comb begin
    gnt_d = gnt_q;
    unique case (gnt_q)
      GNT_NONE: begin
        if (req_vga && req_mire)
          gnt_d = (last_q == M_MIRE) ? GNT_VGA : GNT_MIRE;
        else if (req_vga)
          gnt_d = GNT_VGA;
        else if (req_mire)
          gnt_d = GNT_MIRE;
      end
      GNT_VGA: begin
        if (!wshb_ifs_vga.cyc)
          gnt_d = req_mire ? GNT_MIRE : GNT_NONE;
        else if (ack_hit && cnt_top && req_mire)
          gnt_d = GNT_MIRE;
      end
      GNT_MIRE: begin
        if (!wshb_ifs_mire.cyc)
          gnt_d = req_vga ? GNT_VGA : GNT_NONE;
        else if (ack_hit && cnt_top && req_vga)
          gnt_d = GNT_VGA;
      end
      default: gnt_d = GNT_NONE;
    endcase
  end

  // Tenure counter clears on handover and wraps when uncontended.
  always_comb begin
    cnt_d = cnt_q;
    if (gnt_d != gnt_q)
      cnt_d = '0;
    else if (ack_hit)
      cnt_d = cnt_top ? '0 : cnt_q + CNT_W'(1);
  end

  // Remember who was granted last for tie-breaking.
  always_comb begin
    last_d = last_q;
    if (gnt_d != gnt_q) begin
      if (gnt_d == GNT_VGA)
        last_d = M_VGA;
      else if (gnt_d == GNT_MIRE)
        last_d = M_MIRE;
    end
  end

  // Arbiter state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_q  <= GNT_NONE;
      last_q <= M_MIRE;
      cnt_q  <= '0;
    end else begin
      gnt_q  <= gnt_d;
      last_q <= last_d;
      cnt_q  <= cnt_d;
    end
  end

  wshb_arb_mux #(
    .RW (RW)
  ) u_mux (
    .gnt       (gnt_q),
    .vga_req   (vga_req),
    .mire_req  (mire_req),
    .sdram_req (sdram_req),
    .sdram_ack (wshb_ifm_sdram.ack),
    .sdram_dat (wshb_ifm_sdram.dat_sm),
    .vga_ack   (vga_ack),
    .mire_ack  (mire_ack),
    .vga_dat   (vga_dat),
    .mire_dat  (mire_dat)
  );

  assign {
    wshb_ifm_sdram.adr, wshb_ifm_sdram.dat_ms,
    wshb_ifm_sdram.we, wshb_ifm_sdram.sel,
    wshb_ifm_sdram.cti, wshb_ifm_sdram.bte,
    wshb_ifm_sdram.cyc, wshb_ifm_sdram.stb
  } = sdram_req;

  assign wshb_ifs_vga.ack     = vga_ack;
  assign wshb_ifs_mire.ack    = mire_ack;
  assign wshb_ifs_vga.dat_sm  = vga_dat;
  assign wshb_ifs_mire.dat_sm = mire_dat;

endmodule

// File: tb/tb_wshb_arbiter2.sv
// Self-checking bench for wshb_arbiter2.
// Arbitration table plus scoreboarded multi-cycle sequences.
module tb_wshb_arbiter2;
  import wshb_arb_pkg::*;

  localparam int MAXG = 64;
  localparam logic [31:0] ADR0 = 32'hA000_0010;
  localparam logic [31:0] ADR1 = 32'hB000_0020;
  localparam logic [31:0] SDAT = 32'hC0DE_0001;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic slave_en = 1'b0;

  int n_checks = 0;
  int n_errors = 0;
  int ncyc;

  logic q_own[$];

  wshb_if #(.ADR_W(32)) if_vga ();
  wshb_if #(.ADR_W(32)) if_mire ();
  wshb_if #(.ADR_W(32)) if_sdram ();

  wshb_arbiter2 #(
    .MAX_GRANT (MAXG),
    .ADR_W     (32)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .wshb_ifs_vga   (if_vga),
    .wshb_ifs_mire  (if_mire),
    .wshb_ifm_sdram (if_sdram)
  );

  initial forever #5 clk = ~clk;

  // SDRAM model: acks every cycle it is strobed while enabled.
  assign if_sdram.ack = slave_en & if_sdram.cyc & if_sdram.stb;
  assign if_sdram.dat_sm = SDAT;

  task automatic check(input string name,
                       input logic [95:0] act,
                       input logic [95:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: each ack seen must match the next expected owner.
  always @(negedge clk) begin : mon
    logic own;
    if (rst_n && (if_vga.ack || if_mire.ack)) begin
      if (q_own.size() == 0) begin
        check("unexpected_ack", {if_vga.ack, if_mire.ack}, 2'b00);
      end else begin
        own = q_own.pop_front();
        check("ack_owner", {if_vga.ack, if_mire.ack},
              (own == M_VGA) ? 2'b10 : 2'b01);
        check("ack_adr", if_sdram.adr, (own == M_VGA) ? ADR0 : ADR1);
        check("ack_we", if_sdram.we, (own == M_VGA) ? 1'b0 : 1'b1);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m(input logic r0, input logic r1);
    if_vga.cyc  = r0;
    if_vga.stb  = r0;
    if_mire.cyc = r1;
    if_mire.stb = r1;
  endtask

  task automatic push(input logic own, input int n);
    for (int i = 0; i < n; i++) q_own.push_back(own);
  endtask

  // Wait for the scoreboard to empty; counts rising edges taken.
  task automatic drain(input int bound, output int c);
    c = 0;
    while (q_own.size() != 0 && c < bound) begin
      @(posedge clk);
      c++;
    end
    if (q_own.size() != 0) begin
      check("drain_timeout", q_own.size(), 0);
      q_own.delete();
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    set_m(1'b0, 1'b0);
    q_own.delete();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic check_idle(input string name);
    check({name, "_adr"}, if_sdram.adr, 0);
    check({name, "_dat"}, if_sdram.dat_ms, 0);
    check({name, "_ctl"}, {if_sdram.we, if_sdram.sel, if_sdram.cti,
                           if_sdram.bte, if_sdram.cyc, if_sdram.stb}, 0);
  endtask

  typedef struct {
    logic        r0;
    logic        r1;
    logic [31:0] adr;
    logic        cyc;
  } vec_t;

  vec_t tbl[8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Tie results depend on the running last-owner history.
    tbl[0] = '{1'b1, 1'b1, ADR0, 1'b1};
    tbl[1] = '{1'b1, 1'b1, ADR1, 1'b1};
    tbl[2] = '{1'b1, 1'b0, ADR0, 1'b1};
    tbl[3] = '{1'b1, 1'b0, ADR0, 1'b1};
    tbl[4] = '{1'b1, 1'b1, ADR1, 1'b1};
    tbl[5] = '{1'b0, 1'b1, ADR1, 1'b1};
    tbl[6] = '{1'b1, 1'b1, ADR0, 1'b1};
    tbl[7] = '{1'b0, 1'b0, 32'h0, 1'b0};

    if_vga.adr     = ADR0;
    if_vga.dat_ms  = 32'h1111_1111;
    if_vga.we      = 1'b0;
    if_vga.sel     = 4'hF;
    if_vga.cti     = 3'b000;
    if_vga.bte     = 2'b00;
    if_mire.adr    = ADR1;
    if_mire.dat_ms = 32'h2222_2222;
    if_mire.we     = 1'b1;
    if_mire.sel    = 4'h3;
    if_mire.cti    = 3'b010;
    if_mire.bte    = 2'b01;

    // Reset state with both masters requesting and slave willing.
    rst_n = 1'b0;
    slave_en = 1'b1;
    set_m(1'b1, 1'b1);
    #2;
    check_idle("rst");
    check("rst_acks", {if_vga.ack, if_mire.ack, if_sdram.ack}, 0);
    set_m(1'b0, 1'b0);
    slave_en = 1'b0;
    tick();
    rst_n = 1'b1;

    // Arbitration from idle, one-cycle grant latency.
    for (int i = 0; i < 8; i++) begin
      set_m(1'b0, 1'b0);
      repeat (2) tick();
      @(negedge clk);
      check_idle("idle");
      check("dat_bcast", {if_vga.dat_sm, if_mire.dat_sm}, {SDAT, SDAT});
      @(posedge clk);
      #1;
      set_m(tbl[i].r0, tbl[i].r1);
      @(negedge clk);
      check("grant_latency", if_sdram.cyc, 0);
      @(negedge clk);
      check("grant_adr", if_sdram.adr, tbl[i].adr);
      check("grant_cyc", if_sdram.cyc, tbl[i].cyc);
      tick();
    end
    set_m(1'b0, 1'b0);
    repeat (2) tick();

    // M1 alone, 200 continuous acks, then release to idle.
    slave_en = 1'b1;
    set_m(1'b0, 1'b1);
    push(M_MIRE, 200);
    @(negedge clk);
    check("m1_latency", if_sdram.cyc, 0);
    drain(400, ncyc);
    set_m(1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check_idle("released");
    tick();

    // First tie after reset goes to M0; normal handover to M1.
    do_reset();
    set_m(1'b1, 1'b1);
    push(M_VGA, 10);
    drain(40, ncyc);
    if_vga.cyc = 1'b0;
    if_vga.stb = 1'b0;
    push(M_MIRE, 5);
    @(negedge clk);
    check("release_gap", if_sdram.cyc, 0);
    @(negedge clk);
    check("handover_adr", if_sdram.adr, ADR1);
    drain(40, ncyc);
    set_m(1'b0, 1'b0);
    tick();

    // Continuous contention: alternate every MAXG acks, no bubbles.
    do_reset();
    set_m(1'b1, 1'b1);
    push(M_VGA, MAXG);
    push(M_MIRE, MAXG);
    push(M_VGA, MAXG);
    push(M_MIRE, MAXG);
    drain(600, ncyc);
    check("b2b_cycles", ncyc, 4 * MAXG + 1);
    set_m(1'b0, 1'b0);
    repeat (2) tick();

    // Contender drops on the would-be forced edge: counter wraps.
    do_reset();
    set_m(1'b0, 1'b1);
    push(M_MIRE, MAXG - 1);
    tick();
    set_m(1'b1, 1'b1);
    drain(200, ncyc);
    if_vga.cyc = 1'b0;
    if_vga.stb = 1'b0;
    push(M_MIRE, 1);
    tick();
    set_m(1'b1, 1'b1);
    push(M_MIRE, MAXG);
    push(M_VGA, 3);
    drain(200, ncyc);
    set_m(1'b0, 1'b0);
    repeat (2) tick();

    // Asynchronous reset mid-burst drops the bus at once.
    do_reset();
    set_m(1'b1, 1'b1);
    push(M_VGA, 5);
    drain(40, ncyc);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_cyc", if_sdram.cyc, 0);
    check("arst_stb", if_sdram.stb, 0);
    check("arst_acks", {if_vga.ack, if_mire.ack}, 0);
    q_own.delete();
    tick();
    rst_n = 1'b1;
    push(M_VGA, 3);
    drain(40, ncyc);
    set_m(1'b0, 1'b0);
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
